// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC default,
// fetch FSM state encodings and PC alignment helper.
package ysyx_22040365_ifu_pkg;

  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: one outstanding 32-bit fetch, a held output register
// towards decode, and redirect handling that discards in-flight or held fetches.
//
// state  | meaning
// IDLE   | one cycle after reset, no request
// REQ    | request valid at pc, waiting for memory to accept
// WAIT   | request accepted, waiting for response (drop=1 discards it)
// HOLD   | instruction held for decode until out_ready
module ysyx_22040365_ifu
  import ysyx_22040365_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc
);

  ifu_state_e  state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  logic        capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      out_inst <= '0;
      out_pc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
      if (capture) begin
        out_inst <= imem_resp_data;
        out_pc   <= pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    capture   = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            capture   = 1'b1;
            pc_nxt    = pc + 64'd4;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase

    // A redirect overrides everything; an already-issued request must still
    // have its response absorbed, which is what drop tracks.
    if (redirect_valid) begin
      pc_nxt  = align_pc(redirect_pc);
      capture = 1'b0;
      case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            state_nxt = S_WAIT;
            drop_nxt  = 1'b1;
          end else begin
            state_nxt = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            state_nxt = S_WAIT;
            drop_nxt  = 1'b1;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign out_valid      = (state == S_HOLD);
  assign imem_addr      = pc;

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Directed bench for the fetch unit: a behavioural instruction memory plus
// scoreboards of expected request addresses and expected decode handoffs.
module tb_ysyx_22040365_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;

  ysyx_22040365_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks;
  int          failures;
  int          cyc;
  logic [63:0] req_q[$];
  logic [95:0] out_q[$];
  int          cons_cyc[$];
  logic        fire;
  logic [63:0] fire_addr;
  logic        pend;
  int          pend_cnt;
  logic [63:0] pend_addr;
  int          resp_delay;

  function automatic logic [31:0] memw(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF ^ {a[63:48], 16'h0000};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_fetch(input logic [63:0] a);
    out_q.push_back({a, memw(a)});
  endtask

  // Handshakes are sampled with the inputs already set for the coming edge;
  // the memory model answers resp_delay cycles after an accepted request.
  task automatic step();
    logic [95:0] e;
    if (imem_req_valid && imem_req_ready) begin
      fire      = 1'b1;
      fire_addr = imem_addr;
      if (req_q.size() == 0) chk("req_unexpected", imem_addr, 64'hX);
      else chk("req_addr", imem_addr, req_q.pop_front());
    end
    if (out_valid && out_ready) begin
      cons_cyc.push_back(cyc);
      if (out_q.size() == 0) chk("out_unexpected", out_pc, 64'hX);
      else begin
        e = out_q.pop_front();
        chk("out_pc", out_pc, e[95:32]);
        chk("out_inst", {32'h0, out_inst}, {32'h0, e[31:0]});
      end
    end
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (fire) begin
      pend      = 1'b1;
      pend_cnt  = resp_delay;
      pend_addr = fire_addr;
      fire      = 1'b0;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memw(pend_addr);
        pend            = 1'b0;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_out(input string tag, input int bound);
    int n;
    n = 0;
    while (!out_valid && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_out_valid"}, {63'h0, out_valid}, 64'd1);
  endtask

  initial begin
    int n;
    checks          = 0;
    failures        = 0;
    cyc             = 0;
    fire            = 1'b0;
    fire_addr       = '0;
    pend            = 1'b0;
    pend_cnt        = 0;
    pend_addr       = '0;
    resp_delay      = 1;
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b0;

    step();
    step();
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'd0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_out_inst", {32'h0, out_inst}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_addr", imem_addr, 64'h8000_0000);

    // Back-to-back fetches, memory always ready, 1-cycle response
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_q.push_back(64'h8000_0000 + 64'(4 * i));
      push_fetch(64'h8000_0000 + 64'(4 * i));
    end
    rst_n = 1'b1;
    chk("idle_req_valid", {63'h0, imem_req_valid}, 64'd0);
    step();
    chk("first_req_valid", {63'h0, imem_req_valid}, 64'd1);
    chk("first_req_addr", imem_addr, 64'h8000_0000);
    n = 0;
    while (out_q.size() > 0 && n < 30) begin
      step();
      n++;
    end
    chk("t1_drained", 64'(out_q.size()), 64'd0);
    chk("t1_consumed", 64'(cons_cyc.size()), 64'd3);
    if (cons_cyc.size() == 3) begin
      chk("t1_gap0", 64'(cons_cyc[1] - cons_cyc[0]), 64'd3);
      chk("t1_gap1", 64'(cons_cyc[2] - cons_cyc[1]), 64'd3);
    end

    // Decode stalls 5 cycles with an instruction held
    out_ready = 1'b0;
    req_q.push_back(64'h8000_000C);
    push_fetch(64'h8000_000C);
    wait_out("t2", 10);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_pc", out_pc, 64'h8000_000C);
      chk("hold_inst", {32'h0, out_inst}, {32'h0, memw(64'h8000_000C)});
      chk("hold_no_req", {63'h0, imem_req_valid}, 64'd0);
    end

    // Redirect while WAIT, response two cycles later is discarded
    out_ready  = 1'b1;
    resp_delay = 3;
    req_q.push_back(64'h8000_0010);
    step();
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    req_q.push_back(64'h8000_0100);
    step();
    redirect_valid = 1'b0;
    chk("t3_wait_out_valid", {63'h0, out_valid}, 64'd0);
    chk("t3_wait_req_valid", {63'h0, imem_req_valid}, 64'd0);
    step();
    chk("t3_resp_out_valid", {63'h0, out_valid}, 64'd0);
    step();
    chk("t3_dropped_out_valid", {63'h0, out_valid}, 64'd0);
    chk("t3_req_valid", {63'h0, imem_req_valid}, 64'd1);
    chk("t3_req_addr", imem_addr, 64'h8000_0100);
    resp_delay = 1;
    push_fetch(64'h8000_0100);
    wait_out("t3", 10);

    // Redirect in the same cycle as the response in WAIT
    out_ready = 1'b1;
    req_q.push_back(64'h8000_0104);
    step();
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    req_q.push_back(64'h8000_0200);
    step();
    redirect_valid = 1'b0;
    chk("t4_out_valid", {63'h0, out_valid}, 64'd0);
    chk("t4_req_valid", {63'h0, imem_req_valid}, 64'd1);
    chk("t4_req_addr", imem_addr, 64'h8000_0200);
    push_fetch(64'h8000_0200);
    wait_out("t4", 10);

    // Redirect while HOLD with out_ready: handshake counts, then refetch
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    req_q.push_back(64'h8000_0300);
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    chk("t5_out_valid", {63'h0, out_valid}, 64'd0);
    chk("t5_req_valid", {63'h0, imem_req_valid}, 64'd1);
    chk("t5_req_addr", imem_addr, 64'h8000_0300);
    push_fetch(64'h8000_0300);
    wait_out("t5", 10);
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t5_next_addr", imem_addr, 64'h8000_0304);

    // Redirect to the top of the address space, misaligned bits forced low
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    chk("t6_req_valid", {63'h0, imem_req_valid}, 64'd1);
    chk("t6_req_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready = 1'b1;
    req_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    push_fetch(64'hFFFF_FFFF_FFFF_FFFC);
    wait_out("t6", 10);
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    step();
    out_ready = 1'b0;
    chk("wrap_req_valid", {63'h0, imem_req_valid}, 64'd1);
    chk("wrap_addr", imem_addr, 64'd0);

    // Reset pulse while WAIT; stale response lands in IDLE and is ignored
    resp_delay     = 3;
    imem_req_ready = 1'b1;
    req_q.push_back(64'd0);
    step();
    imem_req_ready = 1'b0;
    chk("t7_wait_req_valid", {63'h0, imem_req_valid}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_req_valid", {63'h0, imem_req_valid}, 64'd0);
    chk("t7_rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("t7_rst_out_inst", {32'h0, out_inst}, 64'd0);
    chk("t7_rst_out_pc", out_pc, 64'd0);
    chk("t7_rst_addr", imem_addr, 64'h8000_0000);
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    chk("t7_idle_req_valid", {63'h0, imem_req_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t7_req_valid", {63'h0, imem_req_valid}, 64'd1);
      chk("t7_out_valid", {63'h0, out_valid}, 64'd0);
      chk("t7_req_addr", imem_addr, 64'h8000_0000);
    end
    resp_delay     = 1;
    imem_req_ready = 1'b1;
    req_q.push_back(64'h8000_0000);
    push_fetch(64'h8000_0000);
    wait_out("t7", 10);
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    step();
    out_ready = 1'b0;
    chk("end_out_q_empty", 64'(out_q.size()), 64'd0);
    chk("end_req_q_empty", 64'(req_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
